// File: rtl/axi_lane_mem_slave_pkg.sv
// Shared types and constants for the AXI4-Lite lane-memory slave.
package vec_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic REQ_WRITE = 1'b1;
  localparam logic REQ_READ  = 1'b0;

  // Shift converting a byte address into an element address.
  function automatic int unsigned byte_shift(input int unsigned width);
    return $clog2(width / 8);
  endfunction

endpackage

// File: rtl/axi_lane_mem_slave_if.sv
// AXI4-Lite bus bundle between the host interconnect and the lane-memory slave.
interface axi_lane_mem_slave_if #(
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned DW     = 128
) ();

  logic [AXI_AW-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AXI_AW-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lane_mem_slave_lane_rd_delay.sv
// Delays the read-request strobe by the lane-memory read latency to time the row capture.
module lane_rd_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_in,
  output logic strobe_out
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr[0] <= strobe_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign strobe_out = sr[DEPTH-1];

endmodule

// File: rtl/axi_lane_mem_slave.sv
// AXI4-Lite slave turning single-beat transactions into one-cycle lane-memory row requests.
module axi_lane_mem_slave
  import vec_axi_pkg::*;
#(
  parameter int unsigned ADDRWIDTH  = 11,
  parameter int unsigned NUMLANES   = 8,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned AXI_AW     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  axi_lane_mem_slave_if.slave         s,
  output logic [ADDRWIDTH-1:0]        axi_addr,
  output logic [NUMLANES*WIDTH-1:0]   axi_data,
  output logic                        axi_req_en,
  output logic                        axi_req_type,
  input  logic [NUMLANES*WIDTH-1:0]   lane_rdata,
  output logic                        busy
);

  localparam int unsigned DW  = NUMLANES * WIDTH;
  localparam int unsigned ESH = byte_shift(WIDTH);
  localparam int unsigned HI  = ADDRWIDTH + ESH;

  state_t               state_q, state_d;
  logic                 rr_last_q, rr_last_d;
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 arready_q, arready_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 rvalid_q, rvalid_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 req_en_q, req_en_d;
  logic                 req_type_q, req_type_d;
  logic                 busy_q, busy_d;

  logic                 wr_cand_c, rd_cand_c;
  logic                 wr_err_c, rd_err_c;
  logic [ADDRWIDTH-1:0] wr_elem_c, rd_elem_c;
  logic                 capture_c;

  assign wr_cand_c = s.awvalid & s.wvalid;
  assign rd_cand_c = s.arvalid;
  assign wr_err_c  = (s.awaddr >> HI) != '0;
  assign rd_err_c  = (s.araddr >> HI) != '0;
  assign wr_elem_c = ADDRWIDTH'(s.awaddr >> ESH);
  assign rd_elem_c = ADDRWIDTH'(s.araddr >> ESH);

  lane_rd_delay #(.DEPTH(RD_LATENCY)) u_rd_delay (
    .clk        (clk),
    .reset      (reset),
    .strobe_in  (req_en_q & (req_type_q == REQ_READ)),
    .strobe_out (capture_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_last_q  <= REQ_WRITE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      req_en_q   <= 1'b0;
      req_type_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      req_en_q   <= req_en_d;
      req_type_q <= req_type_d;
      busy_q     <= busy_d;
    end
  end

  // Next state and next registered outputs; readies raised in IDLE complete the handshake one cycle later.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    arready_d  = 1'b0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    addr_d     = '0;
    data_d     = '0;
    req_en_d   = 1'b0;
    req_type_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (awready_q && wr_cand_c) begin
          if (wr_err_c) begin
            state_d  = S_WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
          end else begin
            state_d    = S_WR_REQ;
            req_en_d   = 1'b1;
            req_type_d = REQ_WRITE;
            addr_d     = wr_elem_c;
            data_d     = s.wdata;
          end
        end else if (arready_q && rd_cand_c) begin
          if (rd_err_c) begin
            state_d  = S_RD_RESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
          end else begin
            state_d    = S_RD_REQ;
            req_en_d   = 1'b1;
            req_type_d = REQ_READ;
            addr_d     = rd_elem_c;
          end
        end else if (!awready_q && !arready_q) begin
          // Round-robin state only moves when both channels compete.
          if (wr_cand_c && rd_cand_c) begin
            if (rr_last_q == REQ_WRITE) begin
              arready_d = 1'b1;
              rr_last_d = REQ_READ;
            end else begin
              awready_d = 1'b1;
              wready_d  = 1'b1;
              rr_last_d = REQ_WRITE;
            end
          end else if (wr_cand_c) begin
            awready_d = 1'b1;
            wready_d  = 1'b1;
          end else if (rd_cand_c) begin
            arready_d = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        state_d  = S_WR_RESP;
        bvalid_d = 1'b1;
        bresp_d  = RESP_OKAY;
      end
      S_WR_RESP: begin
        if (s.bready) begin
          state_d  = S_IDLE;
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (capture_c) begin
          state_d  = S_RD_RESP;
          rvalid_d = 1'b1;
          rresp_d  = RESP_OKAY;
          rdata_d  = lane_rdata;
        end
      end
      S_RD_RESP: begin
        if (s.rready) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
          rresp_d  = RESP_OKAY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign s.awready    = awready_q;
  assign s.wready     = wready_q;
  assign s.arready    = arready_q;
  assign s.bvalid     = bvalid_q;
  assign s.bresp      = bresp_q;
  assign s.rvalid     = rvalid_q;
  assign s.rresp      = rresp_q;
  assign s.rdata      = rdata_q;
  assign axi_addr     = addr_q;
  assign axi_data     = data_q;
  assign axi_req_en   = req_en_q;
  assign axi_req_type = req_type_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_axi_lane_mem_slave.sv
// Randomized bench for axi_lane_mem_slave against a transaction-level row memory model.
module tb_axi_lane_mem_slave;
  import vec_axi_pkg::*;

  localparam int unsigned NL  = 8;
  localparam int unsigned WD  = 16;
  localparam int unsigned DWD = NL * WD;
  localparam int unsigned LAT = 1;
  localparam int unsigned NEL = 2048;

  logic             clk = 1'b0;
  logic             reset;
  logic [10:0]      axi_addr;
  logic [DWD-1:0]   axi_data;
  logic             axi_req_en;
  logic             axi_req_type;
  logic [DWD-1:0]   lane_rdata;
  logic             busy;

  axi_lane_mem_slave_if #(.AXI_AW(32), .DW(DWD)) bus ();

  axi_lane_mem_slave #(
    .ADDRWIDTH(11), .NUMLANES(NL), .WIDTH(WD), .AXI_AW(32), .RD_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s            (bus),
    .axi_addr     (axi_addr),
    .axi_data     (axi_data),
    .axi_req_en   (axi_req_en),
    .axi_req_type (axi_req_type),
    .lane_rdata   (lane_rdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  bit last_wr  = 1'b1;

  bit [15:0] mem     [NEL];
  bit [15:0] ref_mem [NEL];

  // Lane memory stand-in: registered read, garbage on lane_rdata when no read is pending.
  always @(posedge clk) begin
    lane_rdata <= {$urandom, $urandom, $urandom, $urandom};
    if (axi_req_en) begin
      req_cnt++;
      for (int k = 0; k < NL; k++) begin
        if (axi_req_type)
          mem[(int'(axi_addr) + k) % NEL] = axi_data[k*WD +: WD];
        else
          lane_rdata[k*WD +: WD] <= mem[(int'(axi_addr) + k) % NEL];
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a >> 12) != 0;
  endfunction

  function automatic int elem_of(input logic [31:0] a);
    return int'((a >> 1) & 32'h7FF);
  endfunction

  function automatic logic [127:0] ref_row(input int e);
    logic [127:0] r;
    for (int k = 0; k < NL; k++) r[k*WD +: WD] = ref_mem[(e + k) % NEL];
    return r;
  endfunction

  task automatic wait_grant(output int who);
    who = 0;
    for (int i = 0; i < 30 && who == 0; i++) begin
      @(negedge clk);
      if (bus.awready && bus.wready) who = 1;
      else if (bus.arready) who = 2;
    end
    if (who == 0) check("grant_timeout", 0, 1);
    else check("ready_excl", bus.awready & bus.arready, 0);
  endtask

  // Called in the handshake cycle of an accepted write.
  task automatic wr_tail(input logic [31:0] a, input logic [127:0] d, input int stall);
    int c0 = req_cnt;
    bit err = is_err(a);
    int e = elem_of(a);
    logic [1:0] er = err ? RESP_SLVERR : RESP_OKAY;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (err) begin
      check("wr_err_bvalid", bus.bvalid, 1);
      check("wr_err_noreq", axi_req_en, 0);
    end else begin
      check("wr_req_en", axi_req_en, 1);
      check("wr_req_type", axi_req_type, 1);
      check("wr_addr", axi_addr, 128'(e));
      check("wr_data", axi_data, d);
      for (int k = 0; k < NL; k++) ref_mem[(e + k) % NEL] = d[k*WD +: WD];
      @(negedge clk);
      check("wr_req_1cyc", {axi_req_en, axi_addr}, 0);
      check("wr_bvalid", bus.bvalid, 1);
    end
    check("wr_bresp", bus.bresp, er);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("wr_stall_hold", {bus.bvalid, bus.bresp}, {1'b1, er});
      check("wr_stall_rdy", {bus.awready, bus.arready}, 0);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("wr_done", {bus.bvalid, busy}, 0);
    check("wr_req_count", req_cnt - c0, err ? 0 : 1);
  endtask

  // Called in the handshake cycle of an accepted read.
  task automatic rd_tail(input logic [31:0] a, input int stall);
    int c0 = req_cnt;
    bit err = is_err(a);
    int e = elem_of(a);
    logic [1:0] er = err ? RESP_SLVERR : RESP_OKAY;
    logic [127:0] exp = err ? '0 : ref_row(e);
    @(negedge clk);
    bus.arvalid = 1'b0;
    if (err) begin
      check("rd_err_rvalid", bus.rvalid, 1);
      check("rd_err_noreq", axi_req_en, 0);
    end else begin
      check("rd_req_en", axi_req_en, 1);
      check("rd_req_type", axi_req_type, 0);
      check("rd_addr", axi_addr, 128'(e));
      for (int i = 0; i < int'(LAT); i++) begin
        @(negedge clk);
        check("rd_rvalid_early", {bus.rvalid, axi_req_en}, 0);
      end
      @(negedge clk);
      check("rd_rvalid", bus.rvalid, 1);
    end
    check("rd_rresp", bus.rresp, er);
    check("rd_rdata", bus.rdata, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("rd_stall_hold", {bus.rvalid, bus.rresp}, {1'b1, er});
      check("rd_stall_data", bus.rdata, exp);
      check("rd_stall_rdy", {bus.awready, bus.arready}, 0);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("rd_done", {bus.rvalid, busy}, 0);
    check("rd_req_count", req_cnt - c0, err ? 0 : 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [127:0] d, input int stall);
    int who;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    wait_grant(who);
    check("wr_grant", who, 1);
    if (who == 1) wr_tail(a, d, stall);
    else begin bus.awvalid = 1'b0; bus.wvalid = 1'b0; end
  endtask

  task automatic do_read(input logic [31:0] a, input int stall);
    int who;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    wait_grant(who);
    check("rd_grant", who, 2);
    if (who == 2) rd_tail(a, stall);
    else bus.arvalid = 1'b0;
  endtask

  task automatic do_both(input logic [31:0] wa, input logic [127:0] wd,
                         input logic [31:0] ra, input int stall);
    int who;
    int first;
    @(negedge clk);
    bus.awaddr = wa; bus.wdata = wd; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = ra; bus.arvalid = 1'b1;
    first = last_wr ? 2 : 1;
    last_wr = (first == 1);
    wait_grant(who);
    check("arb_first", who, first);
    if (who == 1) wr_tail(wa, wd, stall);
    else if (who == 2) rd_tail(ra, stall);
    if (who != 0) begin
      wait_grant(who);
      check("arb_second", who, 3 - first);
      if (who == 1) wr_tail(wa, wd, stall);
      else if (who == 2) rd_tail(ra, stall);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.bresp,
                          bus.rvalid, bus.rresp, axi_req_en, axi_req_type, axi_addr, busy}, 0);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_data"}, axi_data, 0);
  endtask

  task automatic reset_in_wait();
    int who;
    bit seen = 1'b0;
    @(negedge clk);
    bus.araddr = 32'h40; bus.arvalid = 1'b1;
    wait_grant(who);
    check("rst_rd_grant", who, 2);
    @(negedge clk);
    bus.arvalid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    reset = 1'b0;
    last_wr = 1'b1;
    bus.rready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      seen |= bus.rvalid;
    end
    bus.rready = 1'b0;
    check("rst_no_rvalid", seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0]  a;
    logic [31:0]  ra;
    logic [127:0] d;
    reset = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    do_write(32'h10, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 0);
    do_read(32'h10, 0);
    do_write(32'h10, {8{16'hA5A5}}, 1);
    do_read(32'h10, 5);
    do_read(32'h1000, 0);
    do_write(32'hFFFF_0000, {4{$urandom}}, 2);
    do_read(32'h1000, 3);
    do_write(32'hFFE, {4{32'h1234_5678}}, 0);
    do_read(32'hFFE, 0);
    do_read(32'h8, 0);
    do_both(32'h20, {4{$urandom}}, 32'h20, 0);
    do_both(32'h24, {4{$urandom}}, 32'h22, 1);
    do_both(32'h26, {4{$urandom}}, 32'h20, 0);
    reset_in_wait();
    do_read(32'h10, 0);
    do_both(32'h30, {4{$urandom}}, 32'h30, 0);

    for (int i = 0; i < 40; i++) begin
      int op = $urandom_range(0, 2);
      int st = $urandom_range(0, 3);
      d = {$urandom, $urandom, $urandom, $urandom};
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 255));
      ra = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = 32'hFF0 + 32'($urandom_range(0, 15));
      case (op)
        0: do_write(a, d, st);
        1: do_read(ra, st);
        default: do_both(a, d, ra, st);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
